// File: rtl/video_timing_pkg.sv
// Shared definitions for the run-time video mode controller: mode codes,
// the per-mode timing table and the controller FSM encoding.
package video_timing_pkg;

  localparam logic [1:0] MODE_1080P = 2'd0;
  localparam logic [1:0] MODE_720P  = 2'd1;
  localparam logic [1:0] MODE_480P  = 2'd2;
  localparam logic [1:0] MODE_TEST  = 2'd3;

  // One full timing parameter set; fields are wide enough for every table entry.
  typedef struct packed {
    logic [15:0] h_total, h_fp, h_bp, h_sync, h_act;
    logic [15:0] v_total, v_fp, v_bp, v_sync, v_act;
  } timing_t;

  localparam timing_t T_1080P = '{16'd2200, 16'd88,  16'd148, 16'd44, 16'd1920,
                                  16'd1125, 16'd4,   16'd36,  16'd5,  16'd1080};
  localparam timing_t T_720P  = '{16'd1650, 16'd110, 16'd220, 16'd40, 16'd1280,
                                  16'd750,  16'd5,   16'd20,  16'd5,  16'd720};
  localparam timing_t T_480P  = '{16'd800,  16'd16,  16'd48,  16'd96, 16'd640,
                                  16'd525,  16'd10,  16'd33,  16'd2,  16'd480};
  localparam timing_t T_TEST  = '{16'd170,  16'd18,  16'd16,  16'd8,  16'd128,
                                  16'd120,  16'd8,   16'd32,  16'd8,  16'd72};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_EOF = 2'd1,
    ST_HOLD     = 2'd2,
    ST_SETTLE   = 2'd3
  } state_t;

  function automatic timing_t mode_timing(input logic [1:0] mode);
    timing_t t;
    // NOTE: the default arm guarantees t is assigned on every path, so callers
    // inside always_comb never infer a latch.
    case (mode)
      MODE_720P: t = T_720P;
      MODE_480P: t = T_480P;
      MODE_TEST: t = T_TEST;
      default:   t = T_1080P;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/video_mode_rom.sv
// Combinational lookup from mode code to the ten timing parameters.
module video_mode_rom
  import video_timing_pkg::*;
#(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12
) (
  input  logic [1:0]        mode,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_fp,
  output logic [X_BITS-1:0] h_bp,
  output logic [X_BITS-1:0] h_sync,
  output logic [X_BITS-1:0] h_act,
  output logic [Y_BITS-1:0] v_total,
  output logic [Y_BITS-1:0] v_fp,
  output logic [Y_BITS-1:0] v_bp,
  output logic [Y_BITS-1:0] v_sync,
  output logic [Y_BITS-1:0] v_act
);

  timing_t t;

  // Table lookup for the requested mode.
  always_comb t = mode_timing(mode);

  assign h_total = X_BITS'(t.h_total);
  assign h_fp    = X_BITS'(t.h_fp);
  assign h_bp    = X_BITS'(t.h_bp);
  assign h_sync  = X_BITS'(t.h_sync);
  assign h_act   = X_BITS'(t.h_act);
  assign v_total = Y_BITS'(t.v_total);
  assign v_fp    = Y_BITS'(t.v_fp);
  assign v_bp    = Y_BITS'(t.v_bp);
  assign v_sync  = Y_BITS'(t.v_sync);
  assign v_act   = Y_BITS'(t.v_act);

endmodule

// File: rtl/video_mode_ctrl.sv
// Run-time mode controller: swaps the timing generator's parameter set at a
// frame boundary, holding the generator in reset during the load and
// waiting a few frames before declaring the video valid again.
module video_mode_ctrl
  import video_timing_pkg::*;
#(
  parameter logic [1:0]  DEFAULT_MODE  = 2'd0,
  parameter logic [7:0]  HOLD_CYC      = 8'd16,
  parameter logic [3:0]  SETTLE_FRAMES = 4'd2,
  parameter logic [23:0] EOF_TIMEOUT   = 24'd4_000_000,
  parameter int          X_BITS        = 12,
  parameter int          Y_BITS        = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mode_req,
  input  logic [1:0]        mode_sel,
  input  logic              tg_vs,
  output logic              tg_rstn,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_fp,
  output logic [X_BITS-1:0] h_bp,
  output logic [X_BITS-1:0] h_sync,
  output logic [X_BITS-1:0] h_act,
  output logic [Y_BITS-1:0] v_total,
  output logic [Y_BITS-1:0] v_fp,
  output logic [Y_BITS-1:0] v_bp,
  output logic [Y_BITS-1:0] v_sync,
  output logic [Y_BITS-1:0] v_act,
  output logic [1:0]        cur_mode,
  output logic              busy,
  output logic              mode_ack,
  output logic              mode_err,
  output logic              video_valid
);

  localparam timing_t     DEF_T       = mode_timing(DEFAULT_MODE);
  localparam logic [23:0] HOLD_LAST   = 24'(HOLD_CYC) - 24'd1;
  localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_FRAMES) - 24'd1;
  localparam logic [23:0] EOF_LAST    = EOF_TIMEOUT - 24'd1;

  state_t      state;
  logic [1:0]  pend_mode;
  logic [23:0] cnt;       // shared per-state counter, cleared on every state entry
  logic        tg_vs_d;
  logic        ack_owed;  // set only for host-initiated changes, not the post-reset load
  logic        vs_rise;

  logic [X_BITS-1:0] r_h_total, r_h_fp, r_h_bp, r_h_sync, r_h_act;
  logic [Y_BITS-1:0] r_v_total, r_v_fp, r_v_bp, r_v_sync, r_v_act;

  assign vs_rise = tg_vs & ~tg_vs_d;

  video_mode_rom #(.X_BITS(X_BITS), .Y_BITS(Y_BITS)) u_rom (
    .mode    (pend_mode),
    .h_total (r_h_total), .h_fp (r_h_fp), .h_bp (r_h_bp), .h_sync (r_h_sync), .h_act (r_h_act),
    .v_total (r_v_total), .v_fp (r_v_fp), .v_bp (r_v_bp), .v_sync (r_v_sync), .v_act (r_v_act)
  );

  // Mode-change FSM with all outputs registered; the counter never passes a
  // terminal value because each state leaves as soon as it reaches one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_HOLD;
      pend_mode   <= DEFAULT_MODE;
      cur_mode    <= DEFAULT_MODE;
      cnt         <= '0;
      tg_vs_d     <= 1'b0;
      ack_owed    <= 1'b0;
      tg_rstn     <= 1'b0;
      busy        <= 1'b1;
      video_valid <= 1'b0;
      mode_ack    <= 1'b0;
      mode_err    <= 1'b0;
      h_total     <= X_BITS'(DEF_T.h_total);
      h_fp        <= X_BITS'(DEF_T.h_fp);
      h_bp        <= X_BITS'(DEF_T.h_bp);
      h_sync      <= X_BITS'(DEF_T.h_sync);
      h_act       <= X_BITS'(DEF_T.h_act);
      v_total     <= Y_BITS'(DEF_T.v_total);
      v_fp        <= Y_BITS'(DEF_T.v_fp);
      v_bp        <= Y_BITS'(DEF_T.v_bp);
      v_sync      <= Y_BITS'(DEF_T.v_sync);
      v_act       <= Y_BITS'(DEF_T.v_act);
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below
      // sees pre-edge values and the later arms may safely override defaults.
      tg_vs_d  <= tg_vs;
      mode_ack <= 1'b0;
      mode_err <= mode_req & busy;
      case (state)
        ST_RUN: begin
          if (mode_req) begin
            if (mode_sel == cur_mode) begin
              mode_ack <= 1'b1;
            end else begin
              pend_mode <= mode_sel;
              busy      <= 1'b1;
              cnt       <= '0;
              state     <= ST_WAIT_EOF;
            end
          end
        end
        ST_WAIT_EOF: begin
          if (vs_rise || cnt == EOF_LAST) begin
            state       <= ST_HOLD;
            cnt         <= '0;
            tg_rstn     <= 1'b0;
            video_valid <= 1'b0;
            ack_owed    <= 1'b1;
            cur_mode    <= pend_mode;
            h_total     <= r_h_total;
            h_fp        <= r_h_fp;
            h_bp        <= r_h_bp;
            h_sync      <= r_h_sync;
            h_act       <= r_h_act;
            v_total     <= r_v_total;
            v_fp        <= r_v_fp;
            v_bp        <= r_v_bp;
            v_sync      <= r_v_sync;
            v_act       <= r_v_act;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state   <= ST_SETTLE;
            cnt     <= '0;
            tg_rstn <= 1'b1;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        ST_SETTLE: begin
          if (vs_rise) begin
            if (cnt == SETTLE_LAST) begin
              state       <= ST_RUN;
              cnt         <= '0;
              busy        <= 1'b0;
              video_valid <= 1'b1;
              mode_ack    <= ack_owed;
              ack_owed    <= 1'b0;
            end else begin
              cnt <= cnt + 24'd1;
            end
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Randomized bench for video_mode_ctrl against a frame-level behavioural model.
module tb_video_mode_ctrl;

  localparam int HOLD   = 16;
  localparam int SETTLE = 2;
  localparam int TMO    = 100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mode_req = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic        tg_vs = 1'b0;
  logic        vs_en = 1'b1;
  logic        tg_rstn, busy, mode_ack, mode_err, video_valid;
  logic [1:0]  cur_mode;
  logic [11:0] h_total, h_fp, h_bp, h_sync, h_act;
  logic [11:0] v_total, v_fp, v_bp, v_sync, v_act;

  int n_pass = 0;
  int n_total = 0;

  int tbl [4][10] = '{
    '{2200, 88, 148, 44, 1920, 1125, 4, 36, 5, 1080},
    '{1650, 110, 220, 40, 1280, 750, 5, 20, 5, 720},
    '{800, 16, 48, 96, 640, 525, 10, 33, 2, 480},
    '{170, 18, 16, 8, 128, 120, 8, 32, 8, 72}
  };

  video_mode_ctrl #(
    .DEFAULT_MODE(2'd0), .HOLD_CYC(8'd16), .SETTLE_FRAMES(4'd2),
    .EOF_TIMEOUT(24'd100), .X_BITS(12), .Y_BITS(12)
  ) dut (
    .clk(clk), .rstn(rstn), .mode_req(mode_req), .mode_sel(mode_sel), .tg_vs(tg_vs),
    .tg_rstn(tg_rstn),
    .h_total(h_total), .h_fp(h_fp), .h_bp(h_bp), .h_sync(h_sync), .h_act(h_act),
    .v_total(v_total), .v_fp(v_fp), .v_bp(v_bp), .v_sync(v_sync), .v_act(v_act),
    .cur_mode(cur_mode), .busy(busy), .mode_ack(mode_ack), .mode_err(mode_err),
    .video_valid(video_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [119:0] exp_params(input int m);
    logic [119:0] v = '0;
    for (int i = 0; i < 10; i++) v = {v[107:0], 12'(tbl[m][i])};
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // The generator phase of a change: running, waiting for a frame edge,
  // held in reset, or counting settle frames.
  typedef enum {P_RUN, P_WAIT, P_HOLD, P_SETTLE} phase_t;
  phase_t m_phase;
  int     m_mode, m_pend, m_waited, m_hold_left, m_frames_left;
  bit     m_tgr, m_busy, m_valid, m_ack, m_err, m_owed, m_vs_prev;

  task automatic model_reset();
    m_phase = P_HOLD; m_mode = 0; m_pend = 0; m_hold_left = HOLD;
    m_tgr = 0; m_busy = 1; m_valid = 0; m_ack = 0; m_err = 0; m_owed = 0; m_vs_prev = 0;
    m_waited = 0; m_frames_left = SETTLE;
  endtask

  task automatic model_step();
    bit rise;
    rise = tg_vs && !m_vs_prev;
    m_vs_prev = tg_vs;
    m_ack = 0;
    m_err = mode_req && m_busy;
    case (m_phase)
      P_RUN:
        if (mode_req) begin
          if (int'(mode_sel) == m_mode) m_ack = 1;
          else begin m_pend = int'(mode_sel); m_busy = 1; m_waited = 0; m_phase = P_WAIT; end
        end
      P_WAIT: begin
        m_waited++;
        if (rise || m_waited == TMO) begin
          m_phase = P_HOLD; m_valid = 0; m_tgr = 0; m_mode = m_pend;
          m_hold_left = HOLD; m_owed = 1;
        end
      end
      P_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) begin m_phase = P_SETTLE; m_tgr = 1; m_frames_left = SETTLE; end
      end
      P_SETTLE:
        if (rise) begin
          m_frames_left--;
          if (m_frames_left == 0) begin
            m_phase = P_RUN; m_busy = 0; m_valid = 1; m_ack = m_owed; m_owed = 0;
          end
        end
      default: ;
    endcase
  endtask

  initial model_reset();

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("tg_rstn", tg_rstn, m_tgr);
    check("busy", busy, m_busy);
    check("video_valid", video_valid, m_valid);
    check("mode_ack", mode_ack, m_ack);
    check("mode_err", mode_err, m_err);
    check("cur_mode", cur_mode, m_mode);
    check("params", {h_total, h_fp, h_bp, h_sync, h_act, v_total, v_fp, v_bp, v_sync, v_act},
          exp_params(m_mode));
  end

  // Frame-sync source: short vs pulses every 25..60 cycles, or held low.
  initial begin
    int c;
    int len;
    c = 0; len = 40;
    forever begin
      @(negedge clk);
      if (!vs_en) begin tg_vs = 1'b0; c = 0; end
      else begin
        tg_vs = (c < 3);
        c++;
        if (c >= len) begin c = 0; len = $urandom_range(25, 60); end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input logic [1:0] m);
    @(negedge clk); mode_sel = m; mode_req = 1'b1;
    @(negedge clk); mode_req = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int bound);
    for (int n = 0; n < bound && !video_valid; n++) @(negedge clk);
    check(name, video_valid, 1);
  endtask

  task automatic wait_tgr_low(input string name, input int bound);
    for (int n = 0; n < bound && tg_rstn; n++) @(negedge clk);
    check(name, tg_rstn, 0);
  endtask

  task automatic wait_ack(input string name, input int bound);
    for (int n = 0; n < bound && !mode_ack; n++) @(negedge clk);
    check(name, mode_ack, 1);
  endtask

  task automatic count_hold(input string name);
    int n = 0;
    while (!tg_rstn && n < 100) begin n++; @(negedge clk); end
    check(name, n, HOLD);
  endtask

  initial begin
    int n;
    // Reset state and post-reset bring-up.
    repeat (3) @(negedge clk);
    check("rst_h_total", h_total, 2200);
    check("rst_tg_rstn", tg_rstn, 0);
    check("rst_busy", busy, 1);
    check("rst_valid", video_valid, 0);
    rstn = 1'b1;
    count_hold("rst_hold_len");
    wait_valid("rst_valid_up", 400);
    check("rst_v_total", v_total, 1125);

    // Change to 720p.
    req(2'd1);
    check("chg_busy", busy, 1);
    wait_tgr_low("chg_tgr_low", 200);
    check("chg_h_total", h_total, 1650);
    check("chg_v_total", v_total, 750);
    check("chg_valid_drop", video_valid, 0);
    count_hold("chg_hold_len");
    wait_ack("chg_ack", 400);
    check("chg_cur_mode", cur_mode, 1);

    // Same-mode request acknowledges without disturbance.
    req(2'd1);
    check("same_ack", mode_ack, 1);
    check("same_tgr", tg_rstn, 1);
    check("same_valid", video_valid, 1);

    // Rejected requests during WAIT_EOF and SETTLE.
    req(2'd2);
    req(2'd3);
    check("err_wait", mode_err, 1);
    wait_tgr_low("err_tgr_low", 200);
    for (int k = 0; k < 100 && !tg_rstn; k++) @(negedge clk);
    req(2'd0);
    check("err_settle", mode_err, 1);
    wait_ack("err_ack", 400);
    check("err_cur_mode", cur_mode, 2);

    // Frame-boundary timeout with tg_vs held low.
    vs_en = 1'b0;
    repeat (5) @(negedge clk);
    mode_sel = 2'd3; mode_req = 1'b1;
    @(posedge clk);
    @(negedge clk); mode_req = 1'b0;
    n = 0;
    while (tg_rstn && n < 300) begin @(posedge clk); n++; #1; end
    check("tmo_cycles", n, TMO);
    vs_en = 1'b1;
    wait_ack("tmo_ack", 400);
    check("tmo_h_total", h_total, 170);

    // Reset during HOLD of a 1->3 change.
    req(2'd1);
    wait_ack("abort_pre_ack", 600);
    req(2'd3);
    wait_tgr_low("abort_tgr_low", 200);
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("abort_cur_mode", cur_mode, 0);
    check("abort_h_total", h_total, 2200);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_valid("abort_valid_up", 400);
    check("abort_final_mode", cur_mode, 0);

    // Random requests, checked by the model every cycle.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 120)) @(negedge clk);
      req(2'($urandom));
    end
    for (int k = 0; k < 2000 && busy; k++) @(negedge clk);
    check("final_idle", busy, 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
- Run-time mode controller for the video timing generator.
- Holds the active timing parameter set and drives it onto a register bank that a parameter-port variant of the timing generator consumes.
- On a mode-change request it waits for a frame boundary, holds the generator in reset while new parameters are loaded, releases it, and waits a set number of frames before flagging video valid.
- Sits between the host/key-scan logic and the timing generator, in the pixel clock domain.

Parameters:
- DEFAULT_MODE, 2'd0, mode loaded after reset.
- HOLD_CYC, 8'd16, cycles tg_rstn is held low per mode load.
- SETTLE_FRAMES, 4'd2, tg_vs rising edges after release before video_valid.
- EOF_TIMEOUT, 24'd4_000_000, maximum cycles to wait for a frame boundary.
- X_BITS, 12, horizontal parameter width.
- Y_BITS, 12, vertical parameter width.

Ports:
- clk  in  1  pixel clock.
- rstn  in  1  reset; asynchronous, active-low.
- mode_req  in  1  single-cycle request strobe.
- mode_sel  in  2  requested mode, sampled with mode_req.
- tg_vs  in  1  vs_out from the timing generator.
- tg_rstn  out  1  reset to the timing generator, active-low.
- h_total, h_fp, h_bp, h_sync, h_act  out  X_BITS each  horizontal timing parameters.
- v_total, v_fp, v_bp, v_sync, v_act  out  Y_BITS each  vertical timing parameters.
- cur_mode  out  2  mode currently driven.
- busy  out  1  mode change in progress.
- mode_ack  out  1  one-cycle pulse when a request completes.
- mode_err  out  1  one-cycle pulse when a request is rejected.
- video_valid  out  1  timing is stable and downstream may consume it.

Behaviour:
- Mode table (H total/fp/bp/sync/act ; V total/fp/bp/sync/act):
  - 0 = 1080p: 2200/88/148/44/1920 ; 1125/4/36/5/1080
  - 1 = 720p: 1650/110/220/40/1280 ; 750/5/20/5/720
  - 2 = 480p: 800/16/48/96/640 ; 525/10/33/2/480
  - 3 = test: 170/18/16/8/128 ; 120/8/32/8/72
- Reset (rstn low, asynchronous):
  - state=HOLD, param outputs = DEFAULT_MODE table entry, cur_mode=DEFAULT_MODE.
  - tg_rstn=0, busy=1, video_valid=0, mode_ack=0, mode_err=0, all counters 0.
- tg_vs edge detect: registered tg_vs_d; vs_rise = tg_vs & ~tg_vs_d. Only rising edges count as frame boundaries.
- FSM states: RUN, WAIT_EOF, HOLD, SETTLE.
  - RUN: busy=0, video_valid=1, tg_rstn=1. Sampling mode_req:
    - mode_sel == cur_mode: mode_ack pulses the next cycle; state unchanged; no disturbance to the generator.
    - otherwise: latch pend_mode, busy=1 next cycle, go to WAIT_EOF.
  - WAIT_EOF: video_valid stays 1. Leave on vs_rise, or when the timeout counter reaches EOF_TIMEOUT-1. In the transition cycle, video_valid drops to 0.
  - HOLD: entered with params and cur_mode loaded from pend_mode in the entry cycle. tg_rstn=0 for exactly HOLD_CYC cycles, then go to SETTLE.
  - SETTLE: tg_rstn=1. Count vs_rise up to SETTLE_FRAMES, then go to RUN; mode_ack pulses in the same cycle busy falls and video_valid rises.
  - The post-reset path is HOLD→SETTLE→RUN with no mode_ack.
- Requests while busy=1:
  - Ignored; mode_err pulses one cycle later.
  - pend_mode, params and the FSM are unaffected.
- mode_req in the same cycle as the SETTLE→RUN transition counts as busy and is rejected.
- Param outputs change only on HOLD entry, while tg_rstn is low; they never change while the generator runs.
- Counters saturate at their terminal value and clear on every state entry.
- Reset asserted mid-change aborts it immediately; after release the controller returns to DEFAULT_MODE, and pend_mode is discarded.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Package video_timing_pkg holds:
  - mode encoding constants (MODE_1080P, MODE_720P, MODE_480P, MODE_TEST);
  - the per-mode timing constants;
  - the FSM state encoding.
- One sub-module, video_mode_rom: combinational lookup from mode to the 10 parameter values. The controller registers its output on HOLD entry.

Test Plan:
- Reset release with DEFAULT_MODE=0 → tg_rstn low for 16 cycles; params 2200/1125…; video_valid rises after the 2nd tg_vs rise; no mode_ack.
- mode_req with mode_sel=1 in RUN → busy=1; at next tg_vs rise video_valid=0 and tg_rstn low 16 cycles with h_total=1650, v_total=750; after 2 vs rises mode_ack=1 for one cycle and cur_mode=1.
- mode_req with mode_sel==cur_mode → mode_ack one cycle later; tg_rstn, busy and video_valid unchanged.
- Second mode_req during WAIT_EOF or SETTLE → mode_err single pulse; the first change completes with the first requested mode.
- tg_vs held low, EOF_TIMEOUT=100 → HOLD entered on cycle 100 after the request; the change completes once vs edges resume.
- rstn pulsed low during HOLD of a 1→3 change → immediate return to DEFAULT_MODE params; cur_mode=0; no mode_ack.
